clock_edge_tracker: RTL

CLOCK_EDGE_TRACKER -- requirements
Module: clock_edge_tracker

---
 rtl/clock_edge_tracker.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/clock_edge_tracker.sv
// Observes a divided clock generated in the i_clk domain: strobes its edges, measures
// period and high time, and locks once enough consecutive periods match PERIOD.
module clock_edge_tracker #(
   parameter int PERIOD     = 12,
   parameter int LOCK_COUNT = 4,
   parameter int CNT_W      = 8
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_clk_div,
   output logic             o_rise,
   output logic             o_fall,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high_time,
   output logic             o_locked,
   output logic             o_error,
   output logic [7:0]       o_err_count,
   output logic [1:0]       o_state
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_e;

   localparam int GOOD_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  PER_C    = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0]  TWO_PER  = CNT_W'(2 * PERIOD);
   localparam logic [GOOD_W-1:0] GOOD_ONE = GOOD_W'(1);
   localparam logic [GOOD_W-1:0] LOCK_C   = GOOD_W'(LOCK_COUNT);

   logic              s1_q, s1_d;
   logic              s2_q, s2_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;
   logic [CNT_W-1:0]  pcnt_q, pcnt_d;
   logic [CNT_W-1:0]  hcnt_q, hcnt_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [CNT_W-1:0]  high_q, high_d;
   state_e            state_q, state_d;
   logic [GOOD_W-1:0] good_q, good_d;
   logic              locked_q, locked_d;
   logic              error_q, error_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic              rise_evt;
   logic              fall_evt;

   always_comb begin
      s1_d     = i_clk_div;
      s2_d     = s1_q;
      rise_evt = s1_q & ~s2_q;
      fall_evt = ~s1_q & s2_q;
      rise_d   = rise_evt;
      fall_d   = fall_evt;

      period_d = period_q;
      if (rise_evt) begin
         period_d = pcnt_q;
         pcnt_d   = CNT_ONE;
      end else if (pcnt_q != CNT_MAX) begin
         pcnt_d   = pcnt_q + CNT_ONE;
      end else begin
         pcnt_d   = pcnt_q;
      end

      // High time only feeds o_high_time; it never influences locking.
      high_d = high_q;
      hcnt_d = hcnt_q;
      if (rise_evt) begin
         hcnt_d = CNT_ONE;
      end else if (fall_evt) begin
         high_d = hcnt_q;
      end else if (s1_q && (hcnt_q != CNT_MAX)) begin
         hcnt_d = hcnt_q + CNT_ONE;
      end
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      error_d = 1'b0;
      case (state_q)
         SEARCH: begin
            if (rise_evt) begin
               state_d = TRACK;
               good_d  = '0;
            end
         end
         TRACK: begin
            if (rise_evt) begin
               if (pcnt_q == PER_C) begin
                  good_d = good_q + GOOD_ONE;
                  if ((good_q + GOOD_ONE) == LOCK_C) state_d = LOCKED;
               end else begin
                  error_d = 1'b1;
                  good_d  = '0;
               end
            end else if (pcnt_q == TWO_PER) begin
               error_d = 1'b1;
               good_d  = '0;
               state_d = SEARCH;
            end
         end
         LOCKED: begin
            if (rise_evt) begin
               if (pcnt_q != PER_C) begin
                  error_d = 1'b1;
                  good_d  = '0;
                  state_d = TRACK;
               end
            end else if (pcnt_q == TWO_PER) begin
               // Divided clock has stopped.
               error_d = 1'b1;
               good_d  = '0;
               state_d = SEARCH;
            end
         end
         default: begin
            state_d = SEARCH;
            good_d  = '0;
         end
      endcase

      locked_d  = (state_d == LOCKED);
      err_cnt_d = err_cnt_q;
      if (error_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         pcnt_q    <= '0;
         hcnt_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         state_q   <= SEARCH;
         good_q    <= '0;
         locked_q  <= 1'b0;
         error_q   <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         pcnt_q    <= pcnt_d;
         hcnt_q    <= hcnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         state_q   <= state_d;
         good_q    <= good_d;
         locked_q  <= locked_d;
         error_q   <= error_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign o_rise      = rise_q;
   assign o_fall      = fall_q;
   assign o_period    = period_q;
   assign o_high_time = high_q;
   assign o_locked    = locked_q;
   assign o_error     = error_q;
   assign o_err_count = err_cnt_q;
   assign o_state     = state_q;

endmodule
